id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline register plus EX operand-selection logic, directly upstream of the ALU.
- Latches decoded operands and control from ID, and resolves EX/MEM and MEM/WB forwarding.
- Drives the ALU's two operands and control code; forwards rs2 as store data.
- Detects load-use hazards and inserts its own bubble.

Parameters:
- DATA_LEN, 32, datapath width.
- CTRL_LEN, 3, ALU control code width.
- REG_ADDR_LEN, 5, register index width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- stall_i  in  1  hold all stage registers.
- flush_i  in  1  replace the next stage contents with a bubble.
- valid_i  in  1  ID holds a real instruction.
- rs1_data_i, rs2_data_i  in  DATA_LEN  register-file read data.
- imm_i  in  DATA_LEN  sign-extended immediate.
- rs1_addr_i, rs2_addr_i, rd_addr_i  in  REG_ADDR_LEN  register indices from ID.
- alu_ctrl_i  in  CTRL_LEN  ALU operation code.
- alu_src_i  in  1  selects operand 2: 1 = immediate, 0 = rs2.
- reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i  in  1  control bits.
- exmem_reg_write_i  in  1  EX/MEM writes a register.
- exmem_rd_i  in  REG_ADDR_LEN  EX/MEM destination register.
- exmem_data_i  in  DATA_LEN  EX/MEM result.
- memwb_reg_write_i  in  1  MEM/WB writes a register.
- memwb_rd_i  in  REG_ADDR_LEN  MEM/WB destination register.
- memwb_data_i  in  DATA_LEN  MEM/WB writeback value.
- valid_o  out  1  EX holds a real instruction.
- data1_o, data2_o  out  DATA_LEN  ALU operands.
- store_data_o  out  DATA_LEN  forwarded rs2 value for stores.
- alu_ctrl_o  out  CTRL_LEN  registered ALU code.
- rd_addr_o  out  REG_ADDR_LEN  registered destination register.
- reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o  out  1  registered control bits.
- load_use_hazard_o  out  1  combinational stall request to PC and IF/ID.

Behaviour:
- Reset (rst_i = 0, asynchronous): every stage register is cleared to 0, including valid, all control bits, rd, rs1/rs2 addresses, data, imm, alu_ctrl and alu_src.
  - Consequently valid_o = 0, all control outputs = 0, and data1_o = data2_o = store_data_o = 0.
- Load-use hazard, combinational:
  - load_use_hazard_o = valid_i & valid_q & mem_read_q & (rd_q != 0) & (rd_q == rs1_addr_i | rd_q == rs2_addr_i).
  - The rs2 compare applies regardless of alu_src_i (conservative).
- Register update on the rising clock edge, priority highest first:
  - flush_i: load a bubble. valid, reg_write, mem_read, mem_write and mem_to_reg become 0; rd becomes 0; the data fields also become 0.
  - stall_i: hold every register unchanged.
  - load_use_hazard_o: load a bubble, identical to flush.
  - Otherwise: capture all *_i fields; valid takes valid_i.
  - Control bits are written gated: reg_write_q = reg_write_i & valid_i, and likewise for mem_read and mem_write.
- Simultaneous flush_i and stall_i: flush wins.
- Hazard during stall_i: stall wins; the register holds, and the hazard is re-evaluated next cycle.
- Forwarding, combinational from the registered rs1/rs2 addresses, computed separately for each operand:
  - Priority 1, EX/MEM: if exmem_reg_write_i, exmem_rd_i != 0 and exmem_rd_i == rsX_q, select exmem_data_i.
  - Priority 2, MEM/WB: else if memwb_reg_write_i, memwb_rd_i != 0 and memwb_rd_i == rsX_q, select memwb_data_i.
  - Otherwise: select the registered register-file data.
  - Register x0 is never forwarded.
- Operand outputs:
  - data1_o = fwd_rs1.
  - data2_o = alu_src_q ? imm_q : fwd_rs2.
  - store_data_o = fwd_rs2, always, independent of alu_src.
- Latency: ID inputs appear on the outputs 1 cycle after capture. Forwarding adds no cycles.
- Outputs when valid_o = 0: operand values are don't-care to consumers, but must still equal the forwarding function of the zeroed registers; a bubble therefore yields 0 operands unless forwarding matches.
- Reset mid-stall or mid-hazard: reset overrides immediately; load_use_hazard_o drops to 0 because valid_q = 0.

Test Plan:
- Reset, then load add x3,x1,x2 with rs1_data = 5, rs2_data = 7 and no forwarding → next cycle data1_o = 5, data2_o = 7, valid_o = 1, reg_write_o = 1, rd_addr_o = 3.
- EX/MEM and MEM/WB both target x1: exmem_data = 0xAA, memwb_data = 0xBB, stage rs1 = x1 → data1_o = 0xAA. Drop exmem_reg_write_i → data1_o = 0xBB.
- Forward to x0: exmem_rd = 0, exmem_reg_write = 1, stage rs1 = x0, rs1_data = 0 → data1_o = 0.
- Load-use: stage holds lw x5 (mem_read_q = 1, rd_q = 5), ID presents rs2 = x5 → load_use_hazard_o = 1; next edge valid_o = 0 and reg_write_o = 0.
- addi with alu_src_i = 1, imm = -4 (0xFFFFFFFC), rs2 forwarded = 9 → data2_o = 0xFFFFFFFC, store_data_o = 9.
- stall_i and flush_i held 1 together for 1 cycle with valid_q = 1 → valid_o = 0 after the edge. Then stall_i alone for 2 cycles → all outputs hold. Asserting rst_i = 0 asynchronously mid-stall → outputs go to 0 before the next edge.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use bubble insertion.
// Sits directly upstream of the ALU and supplies its operands, control code and store data.
module id_ex_stage #(
  parameter int DATA_LEN     = 32,
  parameter int CTRL_LEN     = 3,
  parameter int REG_ADDR_LEN = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    stall_i,
  input  logic                    flush_i,
  input  logic                    valid_i,
  input  logic [DATA_LEN-1:0]     rs1_data_i,
  input  logic [DATA_LEN-1:0]     rs2_data_i,
  input  logic [DATA_LEN-1:0]     imm_i,
  input  logic [REG_ADDR_LEN-1:0] rs1_addr_i,
  input  logic [REG_ADDR_LEN-1:0] rs2_addr_i,
  input  logic [REG_ADDR_LEN-1:0] rd_addr_i,
  input  logic [CTRL_LEN-1:0]     alu_ctrl_i,
  input  logic                    alu_src_i,
  input  logic                    reg_write_i,
  input  logic                    mem_read_i,
  input  logic                    mem_write_i,
  input  logic                    mem_to_reg_i,
  input  logic                    exmem_reg_write_i,
  input  logic [REG_ADDR_LEN-1:0] exmem_rd_i,
  input  logic [DATA_LEN-1:0]     exmem_data_i,
  input  logic                    memwb_reg_write_i,
  input  logic [REG_ADDR_LEN-1:0] memwb_rd_i,
  input  logic [DATA_LEN-1:0]     memwb_data_i,
  output logic                    valid_o,
  output logic [DATA_LEN-1:0]     data1_o,
  output logic [DATA_LEN-1:0]     data2_o,
  output logic [DATA_LEN-1:0]     store_data_o,
  output logic [CTRL_LEN-1:0]     alu_ctrl_o,
  output logic [REG_ADDR_LEN-1:0] rd_addr_o,
  output logic                    reg_write_o,
  output logic                    mem_read_o,
  output logic                    mem_write_o,
  output logic                    mem_to_reg_o,
  output logic                    load_use_hazard_o
);

  // valid qualifies the stage contents; a bubble is the all-zero register image.
  typedef struct packed {
    logic                    valid;
    logic                    reg_write;
    logic                    mem_read;
    logic                    mem_write;
    logic                    mem_to_reg;
    logic [REG_ADDR_LEN-1:0] rd;
    logic [REG_ADDR_LEN-1:0] rs1;
    logic [REG_ADDR_LEN-1:0] rs2;
    logic [DATA_LEN-1:0]     rs1_data;
    logic [DATA_LEN-1:0]     rs2_data;
    logic [DATA_LEN-1:0]     imm;
    logic [CTRL_LEN-1:0]     alu_ctrl;
    logic                    alu_src;
  } stage_t;

  stage_t stage_q, stage_d;
  logic   hazard;
  logic [DATA_LEN-1:0] fwd_rs1, fwd_rs2;

  // The rs2 compare is deliberately conservative: it ignores alu_src_i.
  assign hazard = valid_i & stage_q.valid & stage_q.mem_read & (stage_q.rd != '0) &
                  ((stage_q.rd == rs1_addr_i) | (stage_q.rd == rs2_addr_i));

  always_comb begin
    stage_d = stage_q;
    if (flush_i) begin
      stage_d = '0;
    end else if (stall_i) begin
      stage_d = stage_q;
    end else if (hazard) begin
      stage_d = '0;
    end else begin
      stage_d.valid      = valid_i;
      stage_d.reg_write  = reg_write_i & valid_i;
      stage_d.mem_read   = mem_read_i & valid_i;
      stage_d.mem_write  = mem_write_i & valid_i;
      stage_d.mem_to_reg = mem_to_reg_i;
      stage_d.rd         = rd_addr_i;
      stage_d.rs1        = rs1_addr_i;
      stage_d.rs2        = rs2_addr_i;
      stage_d.rs1_data   = rs1_data_i;
      stage_d.rs2_data   = rs2_data_i;
      stage_d.imm        = imm_i;
      stage_d.alu_ctrl   = alu_ctrl_i;
      stage_d.alu_src    = alu_src_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) stage_q <= '0;
    else        stage_q <= stage_d;
  end

  // EX/MEM is the younger result, so it beats MEM/WB; x0 is never forwarded.
  always_comb begin
    fwd_rs1 = stage_q.rs1_data;
    if (exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == stage_q.rs1))
      fwd_rs1 = exmem_data_i;
    else if (memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == stage_q.rs1))
      fwd_rs1 = memwb_data_i;
  end

  always_comb begin
    fwd_rs2 = stage_q.rs2_data;
    if (exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == stage_q.rs2))
      fwd_rs2 = exmem_data_i;
    else if (memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == stage_q.rs2))
      fwd_rs2 = memwb_data_i;
  end

  assign valid_o           = stage_q.valid;
  assign data1_o           = fwd_rs1;
  assign data2_o           = stage_q.alu_src ? stage_q.imm : fwd_rs2;
  assign store_data_o      = fwd_rs2;
  assign alu_ctrl_o        = stage_q.alu_ctrl;
  assign rd_addr_o         = stage_q.rd;
  assign reg_write_o       = stage_q.reg_write;
  assign mem_read_o        = stage_q.mem_read;
  assign mem_write_o       = stage_q.mem_write;
  assign mem_to_reg_o      = stage_q.mem_to_reg;
  assign load_use_hazard_o = hazard;

endmodule
